eth_rx_framer: RTL
==================

ETH_RX_FRAMER -- requirements
Module: eth_rx_framer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits.
REQ-002 SHALL have parameter MAX_WORDS, default 384, longest legal frame in bus words.
REQ-003 SHALL have parameter MIN_WORDS, default 3, shortest legal frame (dest, src, >=1 payload).
REQ-004 SHALL have ports: clk  in  1  clock; reset  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports: inData  in  DATA_W  frame word; inSop  in  1  first word; inEop  in  1  last word; inValid  in  1  word present.
REQ-006 SHALL have ports: inReady  out  1  word accepted when inValid&&inReady; outReady  in  1  downstream can take a beat.
REQ-007 SHALL have ports: wrEnable  out  1  beat valid; outData  out  DATA_W+2  {EOP, SOP, data}; outErr  out  1  beat closes a bad frame.
REQ-008 SHALL have ports: frameLen  out  $clog2(MAX_WORDS+1)  word count of the closing frame; lenValid  out  1  frameLen qualifier.
REQ-009 SHALL have ports: dropCnt  out  16  errored-frame count; goodCnt  out  16  clean-frame count.

Function
REQ-010 SHALL register all outputs; one-cycle latency from accepted input to wrEnable beat.
REQ-011 SHALL hold outData/wrEnable/outErr/lenValid/frameLen stable while wrEnable=1 and outReady=0; inReady = !wrEnable || outReady.
REQ-012 SHALL use states IDLE, DEST, SRC, PAYLOAD, DRAIN; only accepted words advance state.
REQ-013 IDLE: non-SOP words discarded, no beat; SOP word emitted with SOP bit=1 -> DEST's successor SRC (DEST names the state holding the SOP beat, entered only as SOP is accepted).
REQ-014 SRC: word emitted with SOP=EOP=0 -> PAYLOAD; PAYLOAD: words emitted, EOP word emitted with EOP=1 -> IDLE.
REQ-015 Runt: EOP accepted while word count < MIN_WORDS (incl. SOP&&EOP same word) SHALL emit that word with EOP=1, outErr=1 -> IDLE.
REQ-016 Giant: word number MAX_WORDS accepted without EOP SHALL be emitted with EOP forced to 1, outErr=1 -> DRAIN.
REQ-017 SOP accepted outside IDLE/DRAIN SHALL be emitted as closing beat of the current frame (SOP bit=0, EOP=1, outErr=1) -> DRAIN.
REQ-018 DRAIN: all words consumed without beats until an EOP word is accepted -> IDLE; SOP in DRAIN ignored.
REQ-019 lenValid SHALL be 1 exactly on every EOP beat, with frameLen = words emitted for that frame including the EOP beat.
REQ-020 dropCnt SHALL increment on each outErr beat, goodCnt on each clean EOP beat; both saturate at 16'hFFFF.

Reset
REQ-021 reset=0 at a clock edge SHALL force state IDLE, wrEnable=0, outData=0, outErr=0, lenValid=0, frameLen=0, counters=0.
REQ-022 Reset mid-frame SHALL discard the partial frame with no EOP beat emitted; next frame requires a fresh SOP.

Configuration
REQ-023 Macro ETH_RX_STATS_EN defined: dropCnt/goodCnt implemented per REQ-020.
REQ-024 ETH_RX_STATS_EN undefined: counter flops SHALL be absent and dropCnt/goodCnt tied to 0; all other behaviour unchanged.

Structure
REQ-025 Package eth_pkg SHALL hold the state enum type, SOP/EOP bit-offset constants (relative to DATA_W), and the 16-bit counter width constant.
REQ-026 The ready/valid output holding register SHALL be a sub-module eth_rx_outreg, parametrised by width DATA_W+2+1+1+len width.

Verification
REQ-027 Legal 5-word frame 0xA1..0xA5, outReady=1 -> beats 0xA1(SOP)..0xA5(EOP), outErr=0, frameLen=5, goodCnt=1.
REQ-028 Same frame with outReady low cycles 2-4 -> no beat lost/duplicated, outData held constant while stalled, inReady=0 while stalled.
REQ-029 SOP&&EOP single word 0xB0 -> one beat with SOP=EOP=1, outErr=1, frameLen=1, dropCnt=1.
REQ-030 MAX_WORDS=8, 12-word frame -> 8 beats, 8th has EOP=1, outErr=1; words 9-12 no beats; next legal frame passes cleanly.
REQ-031 SOP at word 4 of a frame -> word 4 emitted EOP=1, outErr=1, frameLen=4; rest of new frame dropped until its EOP.
REQ-032 reset=0 at word 3 of 6, release, then legal 3-word frame -> no EOP beat for aborted frame, new frame frameLen=3, counters=0/1.

Source files
------------

// File: rtl/eth_pkg.sv
// -----------------------------------------------------------------------------
// eth_pkg
//   Shared definitions for the Ethernet receive framer slice.
//   - eth_state_e : framer state encoding
//   - SOP_OFS/EOP_OFS : SOP/EOP flag positions in the output beat, counted
//                       upward from bit DATA_W (beat = {EOP, SOP, data})
//   - CNT_W       : width of the frame statistics counters
//   - sat_inc     : saturating increment for the statistics counters
// -----------------------------------------------------------------------------
package eth_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DEST,
      SRC,
      PAYLOAD,
      DRAIN
   } eth_state_e;

   localparam int unsigned SOP_OFS = 0;
   localparam int unsigned EOP_OFS = 1;
   localparam int unsigned CNT_W   = 16;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/eth_rx_outreg.sv
// -----------------------------------------------------------------------------
// eth_rx_outreg
//   Single-entry ready/valid output register. Loads whenever it is empty or
//   its content is being taken downstream; otherwise holds content stable.
//   Ports:
//     clk, reset   clock, synchronous active-low reset
//     valid_i      upstream beat present this cycle
//     data_i       upstream beat content (W bits)
//     ready_o      register can load this cycle (!valid_o || ready_i)
//     valid_o      registered beat valid
//     data_o       registered beat content
//     ready_i      downstream takes the registered beat
// -----------------------------------------------------------------------------
module eth_rx_outreg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   output logic         ready_o,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   input  logic         ready_i
);

   logic         valid_q;
   logic [W-1:0] data_q;

   assign ready_o = !valid_q || ready_i;
   assign valid_o = valid_q;
   assign data_o  = data_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (ready_o) begin
         valid_q <= valid_i;
         data_q  <= data_i;
      end
   end

endmodule

// File: rtl/eth_rx_framer.sv
// -----------------------------------------------------------------------------
// eth_rx_framer
//   Receive-side frame delineation. Accepts words tagged SOP/EOP, forwards
//   well-formed frames one beat per accepted word (one cycle latency), and
//   terminates malformed frames with an errored EOP beat:
//     runt  : EOP before MIN_WORDS words
//     giant : MAX_WORDS words without EOP (rest of frame drained)
//     abort : SOP inside a frame closes the current one (new frame drained)
//   Optional statistics: define ETH_RX_STATS_EN to implement dropCnt/goodCnt;
//   otherwise both are tied to zero and no counter flops exist.
//   Ports:
//     clk, reset          clock, synchronous active-low reset
//     inData/inSop/inEop  input word and its frame markers
//     inValid/inReady     input handshake (accept on inValid && inReady)
//     outReady            downstream can take a beat
//     wrEnable/outData    output beat, outData = {EOP, SOP, data}
//     outErr              beat closes an errored frame
//     frameLen/lenValid   word count of the frame closed by this beat
//     dropCnt/goodCnt     errored / clean frame counters (saturating)
// -----------------------------------------------------------------------------
module eth_rx_framer
   import eth_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_WORDS = 384,
   parameter int unsigned MIN_WORDS = 3
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [DATA_W-1:0]              inData,
   input  logic                           inSop,
   input  logic                           inEop,
   input  logic                           inValid,
   output logic                           inReady,
   input  logic                           outReady,
   output logic                           wrEnable,
   output logic [DATA_W+1:0]              outData,
   output logic                           outErr,
   output logic [$clog2(MAX_WORDS+1)-1:0] frameLen,
   output logic                           lenValid,
   output logic [CNT_W-1:0]               dropCnt,
   output logic [CNT_W-1:0]               goodCnt
);

   localparam int unsigned LEN_W = $clog2(MAX_WORDS+1);
   localparam int unsigned OW    = DATA_W + 2;
   localparam int unsigned REG_W = OW + 1 + 1 + LEN_W;

   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_WORDS);
   localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_WORDS);

   eth_state_e       state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] cnt_inc;

   logic             accept;
   logic             emit;
   logic             beat_sop;
   logic             beat_eop;
   logic             beat_err;

   logic [OW-1:0]    beat_word;
   logic [LEN_W-1:0] beat_len;
   logic             beat_lenv;
   logic [REG_W-1:0] reg_in;
   logic [REG_W-1:0] reg_out;

   assign accept = inValid && inReady;

   // Word number of the word being accepted; the SOP word is always word 1.
   assign cnt_inc = (state_q == IDLE) ? LEN_W'(1) : cnt_q + LEN_W'(1);

   // The destination word is taken directly in IDLE, so DEST is never a
   // resident state; it is handled like SRC should it ever be reached.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      emit     = 1'b0;
      beat_sop = 1'b0;
      beat_eop = 1'b0;
      beat_err = 1'b0;
      if (accept) begin
         case (state_q)
            IDLE: begin
               if (inSop) begin
                  emit     = 1'b1;
                  beat_sop = 1'b1;
                  state_d  = SRC;
               end
            end
            DEST, SRC, PAYLOAD: begin
               emit    = 1'b1;
               state_d = PAYLOAD;
            end
            DRAIN: begin
               if (inEop) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase

         // Closing conditions, highest priority first: abort, EOP, giant.
         if (emit) begin
            cnt_d = cnt_inc;
            if (state_q != IDLE && inSop) begin
               beat_eop = 1'b1;
               beat_err = 1'b1;
               state_d  = DRAIN;
            end else if (inEop) begin
               beat_eop = 1'b1;
               beat_err = (cnt_inc < MIN_L);
               state_d  = IDLE;
            end else if (cnt_inc == MAX_L) begin
               beat_eop = 1'b1;
               beat_err = 1'b1;
               state_d  = DRAIN;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Non-beat cycles load zeros so lenValid/outErr never linger after a beat.
   always_comb begin
      beat_word = '0;
      beat_len  = '0;
      beat_lenv = 1'b0;
      if (emit) begin
         beat_word[DATA_W-1:0]       = inData;
         beat_word[DATA_W + SOP_OFS] = beat_sop;
         beat_word[DATA_W + EOP_OFS] = beat_eop;
         beat_lenv                   = beat_eop;
         beat_len                    = beat_eop ? cnt_inc : '0;
      end
   end

   assign reg_in = {beat_lenv, beat_len, beat_err, beat_word};

   eth_rx_outreg #(
      .W (REG_W)
   ) u_outreg (
      .clk     (clk),
      .reset   (reset),
      .valid_i (emit),
      .data_i  (reg_in),
      .ready_o (inReady),
      .valid_o (wrEnable),
      .data_o  (reg_out),
      .ready_i (outReady)
   );

   assign {lenValid, frameLen, outErr, outData} = reg_out;

`ifdef ETH_RX_STATS_EN
   logic [CNT_W-1:0] drop_q;
   logic [CNT_W-1:0] good_q;

   // Counted when the beat is loaded, so they change with the beat itself.
   always_ff @(posedge clk) begin
      if (!reset) begin
         drop_q <= '0;
         good_q <= '0;
      end else if (inReady && emit) begin
         if (beat_err)      drop_q <= sat_inc(drop_q);
         else if (beat_eop) good_q <= sat_inc(good_q);
      end
   end

   assign dropCnt = drop_q;
   assign goodCnt = good_q;
`else
   assign dropCnt = '0;
   assign goodCnt = '0;
`endif

endmodule
